// File: rtl/lsu_mem_bridge_if.sv
// Word-addressed memory bus between the load/store unit and data memory.
// The bridge is the master; the memory responds with ack and read data.
interface lsu_mem_bridge_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, be, input ack, rdata);
  modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/lsu_mem_bridge.sv
// Load/store bridge: turns single-cycle core memory strobes into a handshaked
// bus transfer, stalling the core until the access completes or times out.
module lsu_mem_bridge #(
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic [2:0]            mem_funct3,
  output logic                  stall,
  output logic [31:0]           rdata,
  output logic                  load_valid,
  output logic                  misaligned,
  output logic                  bus_error,
  lsu_mem_bridge_if.master      bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
  localparam bit TIMEOUT_EN = (TIMEOUT != 0);

  state_e           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic [2:0]       funct3_r;
  logic [1:0]       lane_r;
  logic             access_s;
  logic             illegal_s;

  function automatic logic size_illegal(input logic [2:0] f3, input logic [1:0] lane);
    logic bad;
    case (f3)
      3'b000, 3'b100: bad = 1'b0;
      3'b001, 3'b101: bad = lane[0];
      3'b010:         bad = (lane != 2'b00);
      default:        bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] lane);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = 4'b0011 << lane;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] res;
    case (f3[1:0])
      2'b00:   res = {4{wd[7:0]}};
      2'b01:   res = {2{wd[15:0]}};
      default: res = wd;
    endcase
    return res;
  endfunction

  // Lane select follows the captured byte offset; halves only sit at 0 or 2.
  function automatic logic [31:0] extract_load(input logic [2:0] f3, input logic [1:0] lane,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  res = {{24{b[7]}}, b};
      3'b100:  res = {24'h000000, b};
      3'b001:  res = {{16{h[15]}}, h};
      3'b101:  res = {16'h0000, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Request decode and core stall; stall must rise in the request cycle itself.
  always_comb begin
    access_s   = mem_read | mem_write;
    illegal_s  = size_illegal(mem_funct3, mem_addr[1:0]);
    cnt_next_s = cnt_r + CNT_W'(1);
    misaligned = (state_r == IDLE) && access_s && illegal_s;
    stall      = ((state_r == IDLE) && access_s && !illegal_s) || (state_r == BUSY);
  end

  // Transfer FSM with all bus and result outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      funct3_r   <= 3'b000;
      lane_r     <= 2'b00;
      bus.req    <= 1'b0;
      bus.we     <= 1'b0;
      bus.addr   <= 32'h0000_0000;
      bus.wdata  <= 32'h0000_0000;
      bus.be     <= 4'b0000;
      rdata      <= 32'h0000_0000;
      load_valid <= 1'b0;
      bus_error  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (access_s && !illegal_s) begin
            state_r   <= BUSY;
            cnt_r     <= '0;
            funct3_r  <= mem_funct3;
            lane_r    <= mem_addr[1:0];
            bus.req   <= 1'b1;
            bus.we    <= mem_write;
            bus.addr  <= {mem_addr[31:2], 2'b00};
            bus.be    <= lane_be(mem_funct3, mem_addr[1:0]);
            bus.wdata <= lane_wdata(mem_funct3, mem_wdata);
          end
        end
        BUSY: begin
          // Ack is checked first so a late ack still beats the timeout.
          if (bus.ack) begin
            bus.req <= 1'b0;
            state_r <= DONE;
            if (!bus.we) begin
              rdata      <= extract_load(funct3_r, lane_r, bus.rdata);
              load_valid <= 1'b1;
            end
          end else if (TIMEOUT_EN && (cnt_next_s == CNT_LIMIT)) begin
            bus.req   <= 1'b0;
            bus_error <= 1'b1;
            state_r   <= DONE;
            if (!bus.we) begin
              rdata      <= 32'h0000_0000;
              load_valid <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_next_s;
          end
        end
        DONE: begin
          load_valid <= 1'b0;
          bus_error  <= 1'b0;
          cnt_r      <= '0;
          state_r    <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Directed self-checking bench for lsu_mem_bridge (instance built with TIMEOUT=4).
module tb_lsu_mem_bridge;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0] mem_addr = 32'h0, mem_wdata = 32'h0;
  logic [2:0]  mem_funct3 = 3'b000;
  logic        stall, load_valid, misaligned, bus_error;
  logic [31:0] rdata;
  int          n_cmp = 0, n_err = 0;

  // Results captured by run_access for the calling test to compare.
  int          st_cyc, rq_cyc;
  logic [31:0] o_addr, o_wdata, d_rdata;
  logic [3:0]  o_be;
  logic        o_we, o_mis, d_lv, d_err, hung;

  lsu_mem_bridge_if bus_if ();

  lsu_mem_bridge #(.TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_funct3(mem_funct3),
    .stall(stall), .rdata(rdata), .load_valid(load_valid), .misaligned(misaligned),
    .bus_error(bus_error), .bus(bus_if)
  );

  always #5 clk = ~clk;

  // Runs one core access from IDLE; ack_after = BUSY cycle index that acks (-1 = never).
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input int ack_after, input logic [31:0] rword);
    st_cyc = 0; rq_cyc = 0; o_addr = 32'h0; o_wdata = 32'h0; o_be = 4'h0; o_we = 1'b0;
    o_mis = 1'b0; d_rdata = 32'h0; d_lv = 1'b0; d_err = 1'b0; hung = 1'b1;
    mem_read = rd; mem_write = wr; mem_funct3 = f3; mem_addr = addr; mem_wdata = wd;
    for (int c = 0; c < 32; c++) begin
      bus_if.ack = 1'b0;
      bus_if.rdata = 32'hA5A5_5A5A;
      @(negedge clk);
      if (c == 0) o_mis = misaligned;
      if (stall !== 1'b1) begin
        d_rdata = rdata; d_lv = load_valid; d_err = bus_error; hung = 1'b0;
        break;
      end
      st_cyc++;
      if (bus_if.req === 1'b1) begin
        rq_cyc++;
        if (rq_cyc == 1) begin
          o_addr = bus_if.addr; o_wdata = bus_if.wdata; o_be = bus_if.be; o_we = bus_if.we;
        end
        if (rq_cyc == ack_after) begin
          bus_if.ack = 1'b1;
          bus_if.rdata = rword;
        end
      end
      @(posedge clk); #1;
    end
    mem_read = 1'b0; mem_write = 1'b0;
    bus_if.ack = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (bus_if.req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", bus_if.req); end
    n_cmp++; if (bus_if.we !== 1'b0) begin n_err++; $display("FAIL rst_we: got %b want 0", bus_if.we); end
    n_cmp++; if (bus_if.addr !== 32'h0) begin n_err++; $display("FAIL rst_addr: got %h want 0", bus_if.addr); end
    n_cmp++; if (bus_if.wdata !== 32'h0) begin n_err++; $display("FAIL rst_wdata: got %h want 0", bus_if.wdata); end
    n_cmp++; if (bus_if.be !== 4'b0000) begin n_err++; $display("FAIL rst_be: got %b want 0000", bus_if.be); end
    n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata: got %h want 0", rdata); end
    n_cmp++; if (load_valid !== 1'b0) begin n_err++; $display("FAIL rst_lv: got %b want 0", load_valid); end
    n_cmp++; if (bus_error !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", bus_error); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b want 0", stall); end
    n_cmp++; if (misaligned !== 1'b0) begin n_err++; $display("FAIL rst_mis: got %b want 0", misaligned); end
    @(posedge clk); #1;
  endtask

  task automatic test_lw();
    run_access(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 3, 32'hDEAD_BEEF);
    n_cmp++; if (hung !== 1'b0) begin n_err++; $display("FAIL lw_hung: got %b want 0", hung); end
    n_cmp++; if (o_mis !== 1'b0) begin n_err++; $display("FAIL lw_mis: got %b want 0", o_mis); end
    n_cmp++; if (st_cyc != 4) begin n_err++; $display("FAIL lw_stall_cycles: got %0d want 4", st_cyc); end
    n_cmp++; if (rq_cyc != 3) begin n_err++; $display("FAIL lw_req_cycles: got %0d want 3", rq_cyc); end
    n_cmp++; if (o_addr !== 32'h100) begin n_err++; $display("FAIL lw_addr: got %h want 100", o_addr); end
    n_cmp++; if (o_be !== 4'b1111) begin n_err++; $display("FAIL lw_be: got %b want 1111", o_be); end
    n_cmp++; if (o_we !== 1'b0) begin n_err++; $display("FAIL lw_we: got %b want 0", o_we); end
    n_cmp++; if (d_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL lw_rdata: got %h want deadbeef", d_rdata); end
    n_cmp++; if (d_lv !== 1'b1) begin n_err++; $display("FAIL lw_lv: got %b want 1", d_lv); end
    n_cmp++; if (d_err !== 1'b0) begin n_err++; $display("FAIL lw_err: got %b want 0", d_err); end
    @(negedge clk);
    n_cmp++; if (load_valid !== 1'b0) begin n_err++; $display("FAIL lw_lv_drop: got %b want 0", load_valid); end
    n_cmp++; if (rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL lw_rdata_hold: got %h want deadbeef", rdata); end
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] word;
    logic [3:0]  be;
    logic [31:0] exp;
  } ld_vec_t;

  task automatic test_load_ext();
    ld_vec_t v[8];
    v[0] = '{3'b000, 32'h203, 32'h80FF_FFFF, 4'b1000, 32'hFFFF_FF80};
    v[1] = '{3'b100, 32'h203, 32'h80FF_FFFF, 4'b1000, 32'h0000_0080};
    v[2] = '{3'b000, 32'h201, 32'h0000_7F00, 4'b0010, 32'h0000_007F};
    v[3] = '{3'b001, 32'h202, 32'h80FF_1234, 4'b1100, 32'hFFFF_80FF};
    v[4] = '{3'b101, 32'h202, 32'h80FF_1234, 4'b1100, 32'h0000_80FF};
    v[5] = '{3'b001, 32'h200, 32'h1234_8765, 4'b0011, 32'hFFFF_8765};
    v[6] = '{3'b101, 32'h200, 32'h1234_8765, 4'b0011, 32'h0000_8765};
    v[7] = '{3'b100, 32'h200, 32'h1234_5678, 4'b0001, 32'h0000_0078};
    for (int i = 0; i < 8; i++) begin
      run_access(1'b1, 1'b0, v[i].f3, v[i].addr, 32'h0, 1, v[i].word);
      n_cmp++; if (o_be !== v[i].be) begin n_err++; $display("FAIL ext_be[%0d]: got %b want %b", i, o_be, v[i].be); end
      n_cmp++; if (d_rdata !== v[i].exp) begin n_err++; $display("FAIL ext_rdata[%0d]: got %h want %h", i, d_rdata, v[i].exp); end
      n_cmp++; if (d_lv !== 1'b1) begin n_err++; $display("FAIL ext_lv[%0d]: got %b want 1", i, d_lv); end
    end
  endtask

  task automatic test_store();
    run_access(1'b0, 1'b1, 3'b001, 32'h0000_0006, 32'h1234_ABCD, 1, 32'hFFFF_FFFF);
    n_cmp++; if (o_we !== 1'b1) begin n_err++; $display("FAIL sh_we: got %b want 1", o_we); end
    n_cmp++; if (o_addr !== 32'h4) begin n_err++; $display("FAIL sh_addr: got %h want 4", o_addr); end
    n_cmp++; if (o_be !== 4'b1100) begin n_err++; $display("FAIL sh_be: got %b want 1100", o_be); end
    n_cmp++; if (o_wdata !== 32'hABCD_ABCD) begin n_err++; $display("FAIL sh_wdata: got %h want abcdabcd", o_wdata); end
    n_cmp++; if (d_rdata !== 32'h0000_0078) begin n_err++; $display("FAIL sh_rdata_kept: got %h want 78", d_rdata); end
    n_cmp++; if (d_lv !== 1'b0) begin n_err++; $display("FAIL sh_lv: got %b want 0", d_lv); end
    n_cmp++; if (rq_cyc != 1) begin n_err++; $display("FAIL sh_req_cycles: got %0d want 1", rq_cyc); end
    run_access(1'b0, 1'b1, 3'b000, 32'h0000_0001, 32'h0000_00A5, 1, 32'h0);
    n_cmp++; if (o_be !== 4'b0010) begin n_err++; $display("FAIL sb_be: got %b want 0010", o_be); end
    n_cmp++; if (o_wdata !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL sb_wdata: got %h want a5a5a5a5", o_wdata); end
    // Both strobes high: treated as a store.
    run_access(1'b1, 1'b1, 3'b010, 32'h0000_0008, 32'hCAFE_F00D, 2, 32'h1111_1111);
    n_cmp++; if (o_we !== 1'b1) begin n_err++; $display("FAIL rw_we: got %b want 1", o_we); end
    n_cmp++; if (o_be !== 4'b1111) begin n_err++; $display("FAIL rw_be: got %b want 1111", o_be); end
    n_cmp++; if (o_wdata !== 32'hCAFE_F00D) begin n_err++; $display("FAIL rw_wdata: got %h want cafef00d", o_wdata); end
    n_cmp++; if (d_lv !== 1'b0 || d_rdata !== 32'h78) begin n_err++; $display("FAIL rw_load: got lv=%b rdata=%h want lv=0 rdata=78", d_lv, d_rdata); end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
  } mis_vec_t;

  task automatic test_misaligned();
    mis_vec_t v[7];
    v[0] = '{1'b1, 1'b0, 3'b010, 32'h102};
    v[1] = '{1'b1, 1'b0, 3'b001, 32'h101};
    v[2] = '{1'b1, 1'b0, 3'b101, 32'h003};
    v[3] = '{1'b0, 1'b1, 3'b010, 32'h003};
    v[4] = '{1'b1, 1'b0, 3'b011, 32'h000};
    v[5] = '{1'b0, 1'b1, 3'b110, 32'h000};
    v[6] = '{1'b1, 1'b0, 3'b111, 32'h000};
    for (int i = 0; i < 7; i++) begin
      run_access(v[i].rd, v[i].wr, v[i].f3, v[i].addr, 32'h0, 1, 32'h0);
      n_cmp++; if (o_mis !== 1'b1) begin n_err++; $display("FAIL mis_flag[%0d]: got %b want 1", i, o_mis); end
      n_cmp++; if (st_cyc != 0 || rq_cyc != 0) begin n_err++; $display("FAIL mis_nobus[%0d]: got stall=%0d req=%0d want 0/0", i, st_cyc, rq_cyc); end
      @(negedge clk);
      n_cmp++; if (bus_if.req !== 1'b0) begin n_err++; $display("FAIL mis_req_after[%0d]: got %b want 0", i, bus_if.req); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    run_access(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, -1, 32'h0);
    n_cmp++; if (hung !== 1'b0) begin n_err++; $display("FAIL to_hung: got %b want 0", hung); end
    n_cmp++; if (rq_cyc != 4) begin n_err++; $display("FAIL to_req_cycles: got %0d want 4", rq_cyc); end
    n_cmp++; if (st_cyc != 5) begin n_err++; $display("FAIL to_stall_cycles: got %0d want 5", st_cyc); end
    n_cmp++; if (d_err !== 1'b1) begin n_err++; $display("FAIL to_err: got %b want 1", d_err); end
    n_cmp++; if (d_rdata !== 32'h0) begin n_err++; $display("FAIL to_rdata: got %h want 0", d_rdata); end
    n_cmp++; if (d_lv !== 1'b1) begin n_err++; $display("FAIL to_lv: got %b want 1", d_lv); end
    @(negedge clk);
    n_cmp++; if (bus_error !== 1'b0 || stall !== 1'b0) begin n_err++; $display("FAIL to_clear: got err=%b stall=%b want 0/0", bus_error, stall); end
    @(posedge clk); #1;
    // Ack in the cycle the counter would expire wins.
    run_access(1'b1, 1'b0, 3'b010, 32'h0000_0304, 32'h0, 4, 32'h1122_3344);
    n_cmp++; if (d_err !== 1'b0) begin n_err++; $display("FAIL race_err: got %b want 0", d_err); end
    n_cmp++; if (d_rdata !== 32'h1122_3344) begin n_err++; $display("FAIL race_rdata: got %h want 11223344", d_rdata); end
    n_cmp++; if (rq_cyc != 4) begin n_err++; $display("FAIL race_req_cycles: got %0d want 4", rq_cyc); end
    // Store timeout flags the error but leaves rdata alone.
    run_access(1'b0, 1'b1, 3'b010, 32'h0000_0308, 32'h7777_7777, -1, 32'h0);
    n_cmp++; if (d_err !== 1'b1 || d_lv !== 1'b0) begin n_err++; $display("FAIL sto_flags: got err=%b lv=%b want 1/0", d_err, d_lv); end
    n_cmp++; if (d_rdata !== 32'h1122_3344) begin n_err++; $display("FAIL sto_rdata: got %h want 11223344", d_rdata); end
  endtask

  task automatic test_reset_mid();
    int busy_req;
    mem_read = 1'b1; mem_funct3 = 3'b010; mem_addr = 32'h0000_0400;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++; if (bus_if.req !== 1'b1) begin n_err++; $display("FAIL mid_req_busy: got %b want 1", bus_if.req); end
    reset_n = 1'b0; mem_read = 1'b0;
    #1;
    n_cmp++; if (bus_if.req !== 1'b0) begin n_err++; $display("FAIL mid_req_async: got %b want 0", bus_if.req); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL mid_stall: got %b want 0", stall); end
    n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL mid_rdata: got %h want 0", rdata); end
    n_cmp++; if (bus_if.be !== 4'b0000 || bus_if.addr !== 32'h0) begin n_err++; $display("FAIL mid_bus: got be=%b addr=%h want 0000/0", bus_if.be, bus_if.addr); end
    @(negedge clk); reset_n = 1'b1;
    busy_req = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus_if.req !== 1'b0 || stall !== 1'b0) busy_req++;
    end
    n_cmp++; if (busy_req != 0) begin n_err++; $display("FAIL mid_no_replay: got %0d active cycles want 0", busy_req); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    run_access(1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'h0102_0304, 1, 32'h0);
    n_cmp++; if (st_cyc != 2 || rq_cyc != 1) begin n_err++; $display("FAIL b2b_sw_cycles: got stall=%0d req=%0d want 2/1", st_cyc, rq_cyc); end
    run_access(1'b1, 1'b0, 3'b010, 32'h0000_0014, 32'h0, 1, 32'h5566_7788);
    n_cmp++; if (o_addr !== 32'h14) begin n_err++; $display("FAIL b2b_lw_addr: got %h want 14", o_addr); end
    n_cmp++; if (d_rdata !== 32'h5566_7788) begin n_err++; $display("FAIL b2b_lw_rdata: got %h want 55667788", d_rdata); end
    run_access(1'b1, 1'b0, 3'b000, 32'h0000_0015, 32'h0, 1, 32'h0000_8000);
    n_cmp++; if (o_be !== 4'b0010) begin n_err++; $display("FAIL b2b_lb_be: got %b want 0010", o_be); end
    n_cmp++; if (d_rdata !== 32'hFFFF_FF80) begin n_err++; $display("FAIL b2b_lb_rdata: got %h want ffffff80", d_rdata); end
  endtask

  initial begin
    bus_if.ack = 1'b0;
    bus_if.rdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_lw();
    test_load_ext();
    test_store();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
